// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scanner.
package seven_seg_pkg;
    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Slot-counter width for a 0..div-1 count, never below 1 bit.
    function automatic int cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction
endpackage

// File: rtl/seven_seg_refresh_tick.sv
// Slot counter for the scanner: wrap tick at the last cycle of a slot,
// slot-start flag and the anti-ghosting guard flag.
module seven_seg_refresh_tick
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_wrap,
    output logic o_slot_start,
    output logic o_guard
);
    localparam int CW = cnt_width(REFRESH_DIV);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap       = (r_cnt == CW'(REFRESH_DIV - 1));
    assign o_wrap       = w_wrap;
    assign o_slot_start = (r_cnt == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)       r_cnt <= '0;
        else if (w_wrap) r_cnt <= '0;
        else             r_cnt <= r_cnt + 1'b1;
    end

    generate
        if (GUARD_CYCLES == 0) begin : g_no_guard
            assign o_guard = 1'b0;
        end else begin : g_guard
            assign o_guard = (r_cnt < CW'(GUARD_CYCLES));
        end
    endgenerate
endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with frame-aligned loads.
// Define SEVEN_SEG_LZB_EN to blank leading zeros when a frame commits.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] i_digits_in,
    input  logic                          i_load_valid,
    output logic                          o_load_ready,
    output logic [DIGIT_W-1:0]            o_digit_code,
    output logic [NUM_DIGITS-1:0]         o_anode_n,
    output logic                          o_frame_start
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = DIGIT_W * NUM_DIGITS;

    logic                                 w_wrap, w_slot_start, w_guard;
    logic                                 w_last, w_boundary, w_accept, w_pend_vld_nxt;
    logic [NUM_DIGITS-1:0]                w_anode_on;
    logic [IW-1:0]                        r_idx;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   r_active;
    logic [FW-1:0]                        r_pending;
    logic                                 r_pend_vld;
    logic                                 r_load_ready;
    logic [DIGIT_W-1:0]                   r_digit_code;
    logic [NUM_DIGITS-1:0]                r_anode_n;
    logic                                 r_frame_start;

`ifdef SEVEN_SEG_LZB_EN
    function automatic logic [FW-1:0] commit_val(input logic [FW-1:0] v);
        logic lead;
        lead       = 1'b1;
        commit_val = v;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (lead && v[DIGIT_W*k +: DIGIT_W] == '0)
                commit_val[DIGIT_W*k +: DIGIT_W] = BLANK_CODE;
            else
                lead = 1'b0;
        end
    endfunction
`else
    function automatic logic [FW-1:0] commit_val(input logic [FW-1:0] v);
        return v;
    endfunction
`endif

    seven_seg_refresh_tick #(
        .REFRESH_DIV  (REFRESH_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_tick (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_wrap       (w_wrap),
        .o_slot_start (w_slot_start),
        .o_guard      (w_guard)
    );

    assign w_last     = (r_idx == IW'(NUM_DIGITS - 1));
    assign w_boundary = w_wrap && w_last;
    assign w_accept   = i_load_valid && r_load_ready;
    assign w_anode_on = ~(NUM_DIGITS'(1) << r_idx);

    // Accept only happens with pending empty, so it never collides with a commit.
    always_comb begin
        w_pend_vld_nxt = r_pend_vld;
        if (w_accept)                      w_pend_vld_nxt = 1'b1;
        else if (w_boundary && r_pend_vld) w_pend_vld_nxt = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx         <= '0;
            r_active      <= {NUM_DIGITS{BLANK_CODE}};
            r_pending     <= {NUM_DIGITS{BLANK_CODE}};
            r_pend_vld    <= 1'b0;
            r_load_ready  <= 1'b1;
            r_digit_code  <= BLANK_CODE;
            r_anode_n     <= '1;
            r_frame_start <= 1'b0;
        end else begin
            if (w_wrap)
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            if (w_boundary && r_pend_vld)
                r_active <= commit_val(r_pending);
            if (w_accept)
                r_pending <= i_digits_in;
            r_pend_vld    <= w_pend_vld_nxt;
            r_load_ready  <= !w_pend_vld_nxt;
            r_digit_code  <= r_active[r_idx];
            r_anode_n     <= w_guard ? '1 : w_anode_on;
            r_frame_start <= w_slot_start && (r_idx == '0);
        end
    end

    assign o_load_ready  = r_load_ready;
    assign o_digit_code  = r_digit_code;
    assign o_anode_n     = r_anode_n;
    assign o_frame_start = r_frame_start;
endmodule
